// File: rtl/owl_frame_ctrl.sv
// owl_frame_ctrl: framed byte link controller with TX/RX FIFOs and checksum generation/checking
module owl_frame_ctrl #(
  parameter int FIFO_AW = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       host_wr,
  input  logic [7:0] host_wdata,
  output logic       tx_full,
  input  logic       tx_start,
  output logic       tx_busy,
  output logic       tx_done,
  input  logic       host_rd,
  output logic [7:0] host_rdata,
  output logic       rx_empty,
  output logic       rx_done,
  output logic       rx_err,
  output logic       owl_wctrl,
  output logic [7:0] owl_wdata,
  input  logic       owl_wflag,
  output logic       owl_rctrl,
  input  logic [7:0] owl_rdata,
  input  logic       owl_rflag,
  input  logic       owl_rxsof,
  input  logic       owl_rxeof
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [2:0] {T_IDLE, T_LEN, T_PAY, T_CSUM, T_WAIT} tx_state_t;
  typedef enum logic [2:0] {R_IDLE, R_LEN, R_PAY, R_CSUM, R_END} rx_state_t;

  logic [7:0] tx_mem [DEPTH];
  logic [FIFO_AW-1:0] tx_wp, tx_rp;
  logic [FIFO_AW:0] tx_cnt;
  logic tx_push, tx_pop;
  logic [7:0] tx_head;

  tx_state_t tx_state, tx_state_n;
  logic tx_issue, tx_can;
  logic [7:0] tx_byte, tx_len, tx_rem, tx_sum;

  logic [7:0] rx_mem [DEPTH];
  logic [FIFO_AW-1:0] rx_wp, rx_rp;
  logic [FIFO_AW:0] rx_cnt;
  logic rx_full, rx_wr, rx_rd;

  rx_state_t rx_state, rx_state_n;
  logic rx_acc, rx_push, rx_extra, rx_flag, rx_eof_only;
  logic [7:0] rx_rem, rx_sum;

  assign tx_full = tx_cnt == FULL;
  assign tx_busy = tx_state != T_IDLE;
  assign tx_push = host_wr && !tx_full && !tx_busy;
  assign tx_head = tx_mem[tx_rp];
  assign tx_can = !owl_wflag && !owl_wctrl;

  // TX FIFO: host pushes only while idle, the FSM pops as payload bytes go out
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wp <= '0;
      tx_rp <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) tx_mem[tx_wp] <= host_wdata;
      tx_wp <= tx_push ? tx_wp + FIFO_AW'(1) : tx_wp;
      tx_rp <= tx_pop ? tx_rp + FIFO_AW'(1) : tx_rp;
      tx_cnt <= tx_cnt + (FIFO_AW+1)'(tx_push) - (FIFO_AW+1)'(tx_pop);
    end
  end

  // TX state register
  always_ff @(posedge clk) begin
    if (!rst) tx_state <= T_IDLE;
    else tx_state <= tx_state_n;
  end

  // TX next state: one byte per free transceiver slot, done once the checksum has drained
  always_comb begin
    tx_state_n = tx_state;
    tx_issue = 1'b0;
    tx_byte = 8'h00;
    tx_pop = 1'b0;
    tx_done = 1'b0;
    case (tx_state)
      T_IDLE: tx_state_n = tx_start ? T_LEN : T_IDLE;
      T_LEN: if (tx_can) begin
        tx_issue = 1'b1;
        tx_byte = tx_len;
        tx_state_n = tx_len == 8'd0 ? T_CSUM : T_PAY;
      end
      T_PAY: if (tx_can) begin
        tx_issue = 1'b1;
        tx_byte = tx_head;
        tx_pop = 1'b1;
        tx_state_n = tx_rem == 8'd1 ? T_CSUM : T_PAY;
      end
      T_CSUM: if (tx_can) begin
        tx_issue = 1'b1;
        tx_byte = 8'h00 - tx_sum;
        tx_state_n = T_WAIT;
      end
      T_WAIT: if (tx_can) begin
        tx_done = 1'b1;
        tx_state_n = T_IDLE;
      end
      default: tx_state_n = T_IDLE;
    endcase
  end

  // TX datapath: registered write strobe/byte, frame length and running sum
  always_ff @(posedge clk) begin
    if (!rst) begin
      owl_wctrl <= 1'b0;
      owl_wdata <= 8'h00;
      tx_len <= 8'h00;
      tx_rem <= 8'h00;
      tx_sum <= 8'h00;
    end else begin
      owl_wctrl <= tx_issue;
      if (tx_issue) owl_wdata <= tx_byte;
      if (tx_state == T_IDLE && tx_start) begin
        tx_len <= 8'(tx_cnt);
        tx_rem <= 8'(tx_cnt);
        tx_sum <= 8'h00;
      end else begin
        if (tx_issue) tx_sum <= tx_sum + tx_byte;
        if (tx_pop) tx_rem <= tx_rem - 8'd1;
      end
    end
  end

  assign rx_full = rx_cnt == FULL;
  assign rx_empty = rx_cnt == '0;
  assign host_rdata = rx_mem[rx_rp];
  assign rx_wr = rx_push && !rx_full;
  assign rx_rd = host_rd && !rx_empty;
  assign rx_eof_only = owl_rxeof && !owl_rxsof;
  assign rx_extra = rx_acc && (rx_state == R_END || rx_state == R_IDLE);

  // RX FIFO: payload pushes from the FSM, host pops; both may happen together
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_wp <= '0;
      rx_rp <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_wr) rx_mem[rx_wp] <= owl_rdata;
      rx_wp <= rx_wr ? rx_wp + FIFO_AW'(1) : rx_wp;
      rx_rp <= rx_rd ? rx_rp + FIFO_AW'(1) : rx_rp;
      rx_cnt <= rx_cnt + (FIFO_AW+1)'(rx_wr) - (FIFO_AW+1)'(rx_rd);
    end
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (!rst) rx_state <= R_IDLE;
    else rx_state <= rx_state_n;
  end

  // RX next state: frame start beats frame end, which beats a byte accept in the same cycle
  always_comb begin
    rx_state_n = rx_state;
    rx_acc = 1'b0;
    rx_push = 1'b0;
    if (owl_rxsof) rx_state_n = R_LEN;
    else if (owl_rxeof) rx_state_n = R_IDLE;
    else if (owl_rflag && !owl_rctrl) begin
      rx_acc = 1'b1;
      case (rx_state)
        R_LEN: rx_state_n = owl_rdata == 8'd0 ? R_CSUM : R_PAY;
        R_PAY: begin
          rx_push = 1'b1;
          rx_state_n = rx_rem == 8'd1 ? R_CSUM : R_PAY;
        end
        R_CSUM: rx_state_n = R_END;
        default: rx_state_n = rx_state;
      endcase
    end
  end

  // RX datapath: ack strobe, byte counter, running sum, error flag and frame status
  always_ff @(posedge clk) begin
    if (!rst) begin
      owl_rctrl <= 1'b0;
      rx_done <= 1'b0;
      rx_err <= 1'b0;
      rx_rem <= 8'h00;
      rx_sum <= 8'h00;
      rx_flag <= 1'b0;
    end else begin
      owl_rctrl <= rx_acc;
      rx_done <= rx_eof_only;
      if (rx_eof_only) rx_err <= rx_state != R_END || rx_sum != 8'h00 || rx_flag;
      if (owl_rxsof) begin
        rx_rem <= 8'h00;
        rx_sum <= 8'h00;
        rx_flag <= 1'b0;
      end else if (rx_acc) begin
        rx_sum <= rx_sum + owl_rdata;
        rx_rem <= rx_state == R_LEN ? owl_rdata : rx_state == R_PAY ? rx_rem - 8'd1 : rx_rem;
        if (rx_extra || (rx_push && rx_full)) rx_flag <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_owl_frame_ctrl.sv
// tb_owl_frame_ctrl: scoreboard bench with model transceiver for owl_frame_ctrl
module tb_owl_frame_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic host_wr = 1'b0, tx_start = 1'b0, host_rd = 1'b0;
  logic owl_wflag = 1'b0, owl_rflag = 1'b0, owl_rxsof = 1'b0, owl_rxeof = 1'b0;
  logic [7:0] host_wdata = 8'h00, owl_rdata = 8'h00;
  logic tx_full, tx_busy, tx_done, rx_empty, rx_done, rx_err, owl_wctrl, owl_rctrl;
  logic [7:0] host_rdata, owl_wdata;

  int total = 0, bad = 0;
  int n_w = 0, n_done = 0, n_r = 0, n_rxd = 0, wcnt = 0;
  logic w_prev = 1'b0;
  logic [7:0] exp_w[$];
  logic [7:0] exp_rd[$];
  logic exp_err[$];

  owl_frame_ctrl #(.FIFO_AW(3)) dut (
    .clk(clk), .rst(rst),
    .host_wr(host_wr), .host_wdata(host_wdata), .tx_full(tx_full),
    .tx_start(tx_start), .tx_busy(tx_busy), .tx_done(tx_done),
    .host_rd(host_rd), .host_rdata(host_rdata), .rx_empty(rx_empty),
    .rx_done(rx_done), .rx_err(rx_err),
    .owl_wctrl(owl_wctrl), .owl_wdata(owl_wdata), .owl_wflag(owl_wflag),
    .owl_rctrl(owl_rctrl), .owl_rdata(owl_rdata), .owl_rflag(owl_rflag),
    .owl_rxsof(owl_rxsof), .owl_rxeof(owl_rxeof)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // transceiver TX side: buffer occupied for 40 cycles after each write strobe
  initial forever begin
    tick();
    if (owl_wctrl) begin
      owl_wflag = 1'b1;
      wcnt = 40;
    end else if (wcnt > 0) begin
      wcnt--;
      if (wcnt == 0) owl_wflag = 1'b0;
    end
  end

  // monitor: pops expected values whenever the DUT presents an output event
  initial forever begin
    @(negedge clk);
    if (owl_wctrl) begin
      n_w++;
      chk("wctrl_width", w_prev, 1'b0);
      chk("wctrl_expected", exp_w.size() > 0, 1'b1);
      if (exp_w.size() > 0) chk("wdata", owl_wdata, exp_w.pop_front());
    end
    w_prev = owl_wctrl;
    if (tx_done) n_done++;
    if (owl_rctrl) n_r++;
    if (rx_done) begin
      n_rxd++;
      chk("rx_done_expected", exp_err.size() > 0, 1'b1);
      if (exp_err.size() > 0) chk("rx_err", rx_err, exp_err.pop_front());
    end
    if (host_rd && !rx_empty) begin
      chk("rd_expected", exp_rd.size() > 0, 1'b1);
      if (exp_rd.size() > 0) chk("host_rdata", host_rdata, exp_rd.pop_front());
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] b);
    tick(); host_wr = 1'b1; host_wdata = b;
    tick(); host_wr = 1'b0;
  endtask

  task automatic start();
    tick(); tx_start = 1'b1;
    tick(); tx_start = 1'b0;
  endtask

  task automatic sof();
    tick(); owl_rxsof = 1'b1;
    tick(); owl_rxsof = 1'b0;
  endtask

  task automatic eof();
    tick(); owl_rxeof = 1'b1;
    tick(); owl_rxeof = 1'b0;
    repeat (3) tick();
  endtask

  task automatic send(input logic [7:0] b);
    tick(); owl_rdata = b; owl_rflag = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (owl_rctrl) break;
    end
    chk("rctrl_ack", owl_rctrl, 1'b1);
    owl_rflag = 1'b0;
  endtask

  task automatic rd();
    tick(); host_rd = 1'b1;
    tick(); host_rd = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 3000 && n_done < target; i++) tick();
    repeat (5) tick();
    chk("tx_done_count", n_done, target);
  endtask

  initial begin
    int d, r0, w0;
    repeat (3) tick();
    chk("rst_wctrl", owl_wctrl, 0);
    chk("rst_wdata", owl_wdata, 8'h00);
    chk("rst_rctrl", owl_rctrl, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_tx_done", tx_done, 0);
    chk("rst_rx_done", rx_done, 0);
    chk("rst_rx_err", rx_err, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_empty", rx_empty, 1);
    rst = 1'b1;
    tick();

    // three-byte frame
    push(8'h11); push(8'h22); push(8'h33);
    exp_w = '{8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    d = n_done;
    start();
    chk("busy_after_start", tx_busy, 1);
    wait_done(d + 1);
    chk("busy_after_frame", tx_busy, 0);
    chk("tx_stream_drained", exp_w.size(), 0);

    // overfull TX FIFO: pushes 9 and 10 dropped; push while busy dropped
    for (int i = 1; i <= 10; i++) push(8'(i));
    chk("tx_full_at_8", tx_full, 1);
    exp_w = '{8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hD4};
    d = n_done;
    start();
    push(8'hEE);
    wait_done(d + 1);
    chk("tx_full_after_frame", tx_full, 0);

    // empty frame
    exp_w = '{8'h00, 8'h00};
    d = n_done;
    start();
    wait_done(d + 1);

    // good RX frame
    exp_err.push_back(1'b0);
    r0 = n_r;
    sof(); send(8'h02); send(8'hA0); send(8'h05); send(8'h59); eof();
    chk("rctrl_pulses", n_r - r0, 4);
    chk("rx_nonempty", rx_empty, 0);
    exp_rd = '{8'hA0, 8'h05};
    rd(); rd();
    chk("rx_drained", rx_empty, 1);

    // bad checksum, payload kept
    exp_err.push_back(1'b1);
    sof(); send(8'h02); send(8'hA0); send(8'h05); send(8'h58); eof();
    exp_rd = '{8'hA0, 8'h05};
    rd(); rd();
    chk("rx_drained_bad", rx_empty, 1);

    // ten-byte payload into an eight-deep FIFO
    exp_err.push_back(1'b1);
    sof(); send(8'h0A);
    for (int i = 0; i < 10; i++) send(8'h10 + 8'(i));
    send(8'h29); eof();
    for (int i = 0; i < 8; i++) exp_rd.push_back(8'h10 + 8'(i));
    for (int i = 0; i < 8; i++) rd();
    chk("rx_overflow_drained", rx_empty, 1);

    // end without start, status held afterwards
    exp_err.push_back(1'b1);
    eof();
    repeat (10) tick();
    chk("rx_err_held", rx_err, 1);

    // zero-length frame, then one with an extra byte
    exp_err.push_back(1'b0);
    sof(); send(8'h00); send(8'h00); eof();
    chk("len0_empty", rx_empty, 1);
    exp_err.push_back(1'b1);
    sof(); send(8'h00); send(8'h00); send(8'h00); eof();

    // reset in the middle of a TX payload with RX data pending
    exp_err.push_back(1'b0);
    sof(); send(8'h02); send(8'hA0); send(8'h05); send(8'h59); eof();
    chk("rx_pending", rx_empty, 0);
    push(8'h41); push(8'h42); push(8'h43); push(8'h44);
    exp_w = '{8'h04, 8'h41, 8'h42};
    w0 = n_w;
    start();
    for (int i = 0; i < 500 && n_w < w0 + 3; i++) tick();
    chk("wctrl_before_reset", n_w - w0, 3);
    exp_w.delete();
    tick(); rst = 1'b0;
    tick(); rst = 1'b1;
    chk("rst_mid_busy", tx_busy, 0);
    chk("rst_mid_full", tx_full, 0);
    chk("rst_mid_rx_empty", rx_empty, 1);
    w0 = n_w;
    repeat (60) tick();
    chk("no_wctrl_after_reset", n_w - w0, 0);
    push(8'h5A);
    exp_w = '{8'h01, 8'h5A, 8'hA5};
    d = n_done;
    start();
    wait_done(d + 1);

    chk("rx_done_total", n_rxd, 7);
    chk("exp_w_left", exp_w.size(), 0);
    chk("exp_rd_left", exp_rd.size(), 0);
    chk("exp_err_left", exp_err.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
